uart_ctrl: RTL

Byte-level UART controller between the CPU's MMIO register bus and the UART PHY. It buffers outgoing bytes in a TX FIFO and drains them into the PHY's `tx_data/tx_valid/tx_ready` handshake. It captures the PHY's single-cycle `rx_data/rx_ready` strobes into an RX FIFO, which absorbs software latency and flags overrun. It exposes DATA, STATUS and CTRL registers plus a level interrupt.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_ctrl_if.sv | 14 +
 rtl/sync_fifo.sv | 46 ++++
 rtl/uart_ctrl.sv | 109 ++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared register map and bit positions for the UART controller slice.
package uart_pkg;

    localparam logic [1:0] UART_REG_DATA   = 2'd0;
    localparam logic [1:0] UART_REG_STATUS = 2'd1;
    localparam logic [1:0] UART_REG_CTRL   = 2'd2;

    localparam int unsigned ST_RX_AVAIL = 0;
    localparam int unsigned ST_TX_FULL  = 1;
    localparam int unsigned ST_TX_IDLE  = 2;
    localparam int unsigned ST_OVERRUN  = 3;

    localparam int unsigned CTRL_RX_IE = 0;
    localparam int unsigned CTRL_TX_IE = 1;

endpackage

// File: rtl/uart_ctrl_if.sv
// MMIO register bus between the CPU (master) and the UART controller (slave).
interface uart_ctrl_if;

    logic       reg_req;
    logic       reg_we;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       reg_ack;

    modport master (output reg_req, reg_we, reg_addr, reg_wdata, input reg_rdata, reg_ack);
    modport slave  (input reg_req, reg_we, reg_addr, reg_wdata, output reg_rdata, reg_ack);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head; push on a full FIFO succeeds only alongside a pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A full FIFO frees its head slot in the same edge, so the write may reuse it.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_ctrl.sv
// UART controller: MMIO DATA/STATUS/CTRL registers, TX/RX FIFOs toward the PHY, level interrupt.
module uart_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned fifo_depth = 16
) (
    input  logic        clk,
    input  logic        rst,
    uart_ctrl_if.slave  bus,
    output logic [7:0]  phy_tx_data,
    output logic        phy_tx_valid,
    input  logic        phy_tx_ready,
    input  logic [7:0]  phy_rx_data,
    input  logic        phy_rx_ready,
    output logic        irq
);

    logic [1:0] sel;
    logic       rd;
    logic       wr;
    logic       tx_push;
    logic       tx_pop;
    logic       tx_full;
    logic       tx_empty;
    logic       rx_pop;
    logic [7:0] rx_head;
    logic       rx_full;
    logic       rx_empty;
    logic       ovr_set;
    logic       ovr_clr;
    logic       overrun;
    logic [1:0] ctrl;
    logic [7:0] status;
    logic [7:0] rdata_next;
    logic       unused_addr;

    assign sel         = bus.reg_addr[3:2];
    assign unused_addr = ^bus.reg_addr[1:0];
    assign rd          = bus.reg_req && !bus.reg_we;
    assign wr          = bus.reg_req && bus.reg_we;
    assign tx_push     = wr && (sel == UART_REG_DATA);
    assign rx_pop      = rd && (sel == UART_REG_DATA);
    assign phy_tx_valid = !tx_empty;
    assign tx_pop      = phy_tx_valid && phy_tx_ready;
    // rx_full implies non-empty, so a concurrent DATA read always frees a slot.
    assign ovr_set     = phy_rx_ready && rx_full && !rx_pop;
    assign ovr_clr     = wr && (sel == UART_REG_STATUS) && bus.reg_wdata[ST_OVERRUN];

    sync_fifo #(.WIDTH(8), .DEPTH(fifo_depth)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .din   (bus.reg_wdata),
        .pop   (tx_pop),
        .dout  (phy_tx_data),
        .full  (tx_full),
        .empty (tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(fifo_depth)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (phy_rx_ready),
        .din   (phy_rx_data),
        .pop   (rx_pop),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_comb begin
        status              = '0;
        status[ST_RX_AVAIL] = !rx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_IDLE]  = tx_empty && phy_tx_ready;
        status[ST_OVERRUN]  = overrun;
    end

    always_comb begin
        rdata_next = '0;
        if (rd) begin
            case (sel)
                UART_REG_DATA:   rdata_next = rx_empty ? 8'h00 : rx_head;
                UART_REG_STATUS: rdata_next = status;
                UART_REG_CTRL:   rdata_next = {6'b0, ctrl};
                default:         rdata_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.reg_ack   <= 1'b0;
            bus.reg_rdata <= '0;
            irq           <= 1'b0;
            overrun       <= 1'b0;
            ctrl          <= '0;
        end else begin
            bus.reg_ack   <= bus.reg_req;
            bus.reg_rdata <= rdata_next;
            irq           <= (ctrl[CTRL_RX_IE] && !rx_empty) || (ctrl[CTRL_TX_IE] && tx_empty);
            if (ovr_set)      overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;
            if (wr && (sel == UART_REG_CTRL))
                ctrl <= {bus.reg_wdata[CTRL_TX_IE], bus.reg_wdata[CTRL_RX_IE]};
        end
    end

endmodule
